vmicro16_apb_master: RTL and testbench
======================================

VMICRO16_APB_MASTER -- requirements
Module: vmicro16_apb_master

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 16: data bus width.
- ADDR_WIDTH, 16: core-side word address width.
- CORE_ID_BITS, 3: width of the core ID field in PADDR.
- CORE_ID, 0: ID of the owning core, driven into PADDR.
- TIMEOUT, 255: ACCESS cycles without PREADY before abort; 0 disables the timeout.
REQ-002 APB_WIDTH SHALL equal ADDR_WIDTH+CORE_ID_BITS+2, with PADDR layout:
- [APB_WIDTH-1] = lwex
- [APB_WIDTH-2] = swex
- next CORE_ID_BITS bits = CORE_ID
- [ADDR_WIDTH-1:0] = address
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock, all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- req_valid, in, 1: core request present.
- req_ready, out, 1: block can accept a request.
- req_write, in, 1: 1 = store, 0 = load.
- req_lwex, in, 1: load-exclusive qualifier.
- req_swex, in, 1: store-exclusive qualifier.
- req_addr, in, ADDR_WIDTH: word address.
- req_wdata, in, DATA_WIDTH: store data.
- resp_valid, out, 1: one-cycle response strobe.
- resp_rdata, out, DATA_WIDTH: sampled PRDATA.
- resp_err, out, 1: transfer aborted by timeout.
- M_PADDR, out, APB_WIDTH: APB address.
- M_PWRITE, out, 1: APB write.
- M_PSELx, out, 1: APB select.
- M_PENABLE, out, 1: APB enable.
- M_PWDATA, out, DATA_WIDTH: APB write data.
- M_PRDATA, in, DATA_WIDTH: APB read data, already muxed by the interconnect.
- M_PREADY, in, 1: APB ready, already muxed by the interconnect.

Function
REQ-004 The FSM SHALL have four states:
- IDLE: req_ready=1, PSELx=0, PENABLE=0.
- SETUP: PSELx=1, PENABLE=0.
- ACCESS: PSELx=1, PENABLE=1.
- RESP: resp_valid=1, PSELx=0, PENABLE=0.
REQ-005 A handshake SHALL occur when req_valid && req_ready at a rising edge.
REQ-006 On handshake at edge T, the block SHALL register PADDR, PWRITE and PWDATA, and SHALL present SETUP during cycle T+1.
REQ-007 SETUP SHALL always last exactly one cycle, then go to ACCESS.
REQ-008 ACCESS SHALL hold while M_PREADY=0.
REQ-009 When M_PREADY=1 in ACCESS, the block SHALL capture M_PRDATA into resp_rdata, clear resp_err, and enter RESP the next cycle.
REQ-010 RESP SHALL last exactly one cycle and then return to IDLE; resp_valid has no backpressure.
REQ-011 Minimum request-to-response latency SHALL be 3 cycles (handshake T, resp_valid at T+3); each wait state adds 1 cycle.
REQ-012 M_PADDR, M_PWRITE and M_PWDATA SHALL stay stable from SETUP through the final ACCESS cycle.
REQ-013 M_PADDR, M_PWRITE and M_PWDATA SHALL hold their last value in IDLE and RESP.
REQ-014 resp_rdata SHALL be captured on writes as well as reads, so that a swex status word from the slave reaches the core.
REQ-015 resp_rdata SHALL hold its value until the next capture.
REQ-016 The address SHALL be passed unmodified into M_PADDR[ADDR_WIDTH-1:0].
REQ-017 If req_lwex and req_swex are both 1, the block SHALL issue the transfer with both bits set; resolving this is the slave's responsibility.
REQ-018 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with M_PREADY=0.
REQ-019 On the cycle the counter equals TIMEOUT-1 with M_PREADY=0, the block SHALL enter RESP next with resp_err=1 and resp_rdata=0.
REQ-020 If M_PREADY=1 on the same cycle the timeout fires, M_PREADY SHALL win (normal completion, resp_err=0).
REQ-021 The timeout counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.
REQ-022 With TIMEOUT=0, ACCESS SHALL wait indefinitely.
REQ-023 req_ready SHALL be 0 outside IDLE; requests presented then are ignored, not queued.
REQ-024 PENABLE SHALL never be 1 without PSELx.
REQ-025 PSELx SHALL never rise directly into PENABLE=1.

Reset
REQ-026 While reset=1 at an edge, the block SHALL go to IDLE and drive the following values:
- req_ready=1
- M_PSELx=0, M_PENABLE=0, M_PWRITE=0
- M_PADDR=0, M_PWDATA=0
- resp_valid=0, resp_rdata=0, resp_err=0
- timeout counter=0
REQ-027 Reset in SETUP, ACCESS or RESP SHALL abort the transfer with no resp_valid; PSELx=0 on the cycle after the reset edge.
REQ-028 A handshake on the reset edge SHALL be discarded.

Verification
REQ-029 Read, zero wait: req addr=0x0012, write=0, CORE_ID=2; slave PREADY=1 in the first ACCESS cycle with PRDATA=0xBEEF. Required response:
- M_PADDR = {0,0,3'b010,16'h0012}
- resp_valid at T+3 with rdata=0xBEEF, err=0
REQ-030 Write, two wait states: wdata=0x1234, addr=0x0005; PREADY asserted on the 3rd ACCESS cycle. Required response:
- PWDATA/PADDR stable throughout
- resp_valid at T+5
REQ-031 Store-exclusive: req_swex=1, write=1; slave returns PRDATA=0x0001. Required response:
- PADDR[APB_WIDTH-2]=1
- resp_rdata=0x0001
REQ-032 Timeout, TIMEOUT=4, PREADY held 0. Required response:
- exactly 4 ACCESS cycles
- resp_valid with err=1, rdata=0
- PSELx=0 after
REQ-033 Timeout collision, TIMEOUT=4, PREADY=1 on the 4th ACCESS cycle. Required response:
- err=0, rdata=PRDATA
REQ-034 Reset mid-ACCESS, then back-to-back requests. Required response:
- no resp_valid for the aborted transfer
- PSELx=0 next cycle
- after reset, two back-to-back requests complete in order
- second handshake no earlier than the cycle after resp_valid

Source files
------------

// File: rtl/vmicro16_apb_master.sv
// vmicro16_apb_master
//
// Purpose:
//   Bridges a single core-side load/store request onto an APB bus.
//   Each accepted request becomes one APB transfer: SETUP, then ACCESS
//   until the slave answers (or the timeout fires), then a one-cycle RESP
//   strobe back to the core. Only one transfer can be in flight at a time.
//   Requests that arrive while busy are ignored.
//
// Parameters:
//   DATA_WIDTH   - data bus width
//   ADDR_WIDTH   - core-side word address width
//   CORE_ID_BITS - width of the core ID field in M_PADDR
//   CORE_ID      - ID of the owning core, placed in M_PADDR
//   TIMEOUT      - ACCESS cycles without M_PREADY before abort (0 = never)
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   req_valid/ready    - core request handshake
//   req_write          - 1 = store, 0 = load
//   req_lwex/req_swex  - load/store-exclusive qualifiers
//   req_addr/req_wdata - word address and store data
//   resp_valid         - one-cycle response strobe (no backpressure)
//   resp_rdata         - captured M_PRDATA (also on writes, for swex status)
//   resp_err           - transfer aborted by timeout
//   M_*                - APB master signals; M_PRDATA/M_PREADY come
//                        pre-muxed by the interconnect
//
// M_PADDR layout: {lwex, swex, CORE_ID, address}

module vmicro16_apb_master #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int CORE_ID_BITS = 3,
  parameter int CORE_ID      = 0,
  parameter int TIMEOUT      = 255,
  localparam int APB_WIDTH   = ADDR_WIDTH + CORE_ID_BITS + 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_lwex,
  input  logic                  req_swex,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,

  output logic [APB_WIDTH-1:0]  M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY
);

  // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates;
  // in that configuration the timeout compare is disabled anyway.
  localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0]        TO_LAST   = TO_LAST_I[CNT_W-1:0];
  localparam logic [CORE_ID_BITS-1:0] CORE_ID_F = CORE_ID[CORE_ID_BITS-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q,  state_d;
  logic [APB_WIDTH-1:0]  paddr_q,  paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  err_q,    err_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  // State and datapath registers. Reset wins over any handshake on the
  // same edge, so a request presented together with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update. Address/write/data are only loaded on
  // a handshake, so they stay stable across the transfer and hold afterwards.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_SETUP;
          paddr_d  = {req_lwex, req_swex, CORE_ID_F, req_addr};
          pwrite_d = req_write;
          pwdata_d = req_wdata;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end

      S_ACCESS: begin
        // PREADY is tested first so it wins a collision with the timeout.
        if (M_PREADY) begin
          state_d = S_RESP;
          rdata_d = M_PRDATA;
          err_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs decoded purely from the current state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    M_PSELx    = 1'b0;
    M_PENABLE  = 1'b0;

    case (state_q)
      S_IDLE:   req_ready  = 1'b1;
      S_SETUP:  M_PSELx    = 1'b1;
      S_ACCESS: begin
        M_PSELx   = 1'b1;
        M_PENABLE = 1'b1;
      end
      S_RESP:   resp_valid = 1'b1;
      default:  req_ready  = 1'b0;
    endcase
  end

  assign M_PADDR    = paddr_q;
  assign M_PWRITE   = pwrite_q;
  assign M_PWDATA   = pwdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_vmicro16_apb_master.sv
// tb_vmicro16_apb_master
//
// Purpose:
//   Self-checking bench for vmicro16_apb_master (CORE_ID=2, TIMEOUT=4).
//   A transaction-level model predicts, from the handshake cycle and the
//   number of ACCESS cycles, which phase the bus must be in every cycle and
//   what the response must carry; a per-cycle compare process checks all
//   outputs against it. Directed transfers also pin literal values.
//
// Ports: none (top-level bench).

module tb_vmicro16_apb_master;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int CIB  = 3;
  localparam int CID  = 2;
  localparam int TO   = 4;
  localparam int APBW = AW + CIB + 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic            req_lwex = 1'b0;
  logic            req_swex = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic            resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic [APBW-1:0] M_PADDR;
  logic            M_PWRITE;
  logic            M_PSELx;
  logic            M_PENABLE;
  logic [DW-1:0]   M_PWDATA;
  logic [DW-1:0]   M_PRDATA = '0;
  logic            M_PREADY = 1'b0;

  always #5 clk = ~clk;

  vmicro16_apb_master #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CORE_ID_BITS(CIB),
    .CORE_ID     (CID),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_lwex  (req_lwex),
    .req_swex  (req_swex),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .M_PADDR   (M_PADDR),
    .M_PWRITE  (M_PWRITE),
    .M_PSELx   (M_PSELx),
    .M_PENABLE (M_PENABLE),
    .M_PWDATA  (M_PWDATA),
    .M_PRDATA  (M_PRDATA),
    .M_PREADY  (M_PREADY)
  );

  int totalCount = 0;
  int badCount   = 0;

  // Cycle numbering: the cycle following the N-th rising edge is cycle N.
  int edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Transaction model: handshake cycle, ACCESS length and expected results.
  bit              mActive = 1'b0;
  int              mHs = 0;
  int              mN = 0;
  logic            mErr = 1'b0;
  logic [DW-1:0]   mRdata = '0;
  logic [APBW-1:0] expPaddr = '0;
  logic            expPwrite = 1'b0;
  logic [DW-1:0]   expPwdata = '0;
  logic [DW-1:0]   curRdata = '0;
  logic            curErr = 1'b0;
  bit              checkEn = 1'b0;
  int              respCycle = -1;
  int              accCnt = 0;

  int  cmpD;
  bit  inSetup, inAccess, inResp;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, edgeCount);
    end
  endtask

  function automatic bit modelIdle();
    return !mActive || ((edgeCount - mHs) > (mN + 2));
  endfunction

  task automatic modelReset();
    mActive   = 1'b0;
    expPaddr  = '0;
    expPwrite = 1'b0;
    expPwdata = '0;
    curRdata  = '0;
    curErr    = 1'b0;
  endtask

  // Per-cycle comparison: phase is d cycles after handshake cycle T;
  // d=1 SETUP, d=2..N+1 ACCESS, d=N+2 RESP, otherwise IDLE.
  always @(negedge clk) begin
    if (checkEn) begin
      cmpD     = edgeCount - mHs;
      inSetup  = mActive && (cmpD == 1);
      inAccess = mActive && (cmpD >= 2) && (cmpD <= mN + 1);
      inResp   = mActive && (cmpD == mN + 2);
      if (inResp) begin
        curRdata = mRdata;
        curErr   = mErr;
      end
      checkOutput("req_ready",  32'(req_ready),  32'(!(inSetup || inAccess || inResp)));
      checkOutput("psel",       32'(M_PSELx),    32'(inSetup || inAccess));
      checkOutput("penable",    32'(M_PENABLE),  32'(inAccess));
      checkOutput("resp_valid", 32'(resp_valid), 32'(inResp));
      checkOutput("paddr",      32'(M_PADDR),    32'(expPaddr));
      checkOutput("pwrite",     32'(M_PWRITE),   32'(expPwrite));
      checkOutput("pwdata",     32'(M_PWDATA),   32'(expPwdata));
      checkOutput("resp_rdata", 32'(resp_rdata), 32'(curRdata));
      checkOutput("resp_err",   32'(resp_err),   32'(curErr));
      if (M_PENABLE) accCnt++;
      if (resp_valid && respCycle < 0) respCycle = edgeCount;
    end
  end

  // Issue one request and play the slave. readyOn = ACCESS cycle (1-based)
  // on which PREADY rises, 0 = never. junk keeps req_valid high with other
  // fields while busy; abortD asserts reset in that cycle of the transfer.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic wr,
                               input logic lw, input logic sw,
                               input logic [DW-1:0] wdata, input int readyOn,
                               input logic [DW-1:0] prdata, input bit junk,
                               input int abortD, output int hs);
    int d;
    int guard;
    bit hit;
    req_addr  = addr;
    req_write = wr;
    req_lwex  = lw;
    req_swex  = sw;
    req_wdata = wdata;
    req_valid = 1'b1;
    guard = 0;
    while (!modelIdle() && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    hs        = edgeCount - 1;
    mHs       = hs;
    mActive   = 1'b1;
    mErr      = !(readyOn >= 1 && readyOn <= TO);
    mN        = mErr ? TO : readyOn;
    mRdata    = mErr ? '0 : prdata;
    expPaddr  = {lw, sw, 3'(CID), addr};
    expPwrite = wr;
    expPwdata = wdata;
    respCycle = -1;
    accCnt    = 0;
    if (junk) begin
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_write = ~wr;
      req_swex  = ~sw;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      d = edgeCount - mHs;
      if (abortD > 0 && d == abortD) begin
        reset     = 1'b1;
        M_PREADY  = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        return;
      end
      if (d >= mN + 2) begin
        M_PREADY  = 1'b0;
        req_valid = 1'b0;
        return;
      end
      if (d == 1) begin
        // PREADY during SETUP must be ignored.
        M_PREADY = 1'b1;
        M_PRDATA = 16'hFFFF;
      end else begin
        hit      = ((d - 1) == readyOn);
        M_PREADY = hit;
        M_PRDATA = hit ? prdata : 16'hA5A5;
      end
    end
    totalCount++;
    badCount++;
    $display("[TB] FAIL txn_bound: got no RESP want RESP within 20 cycles");
  endtask

  initial begin
    int hs, hsA, hsB;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkEn = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_psel",  32'(M_PSELx),   32'd0);

    // Handshake on a reset edge is dropped.
    @(negedge clk);
    req_addr  = 16'h7777;
    req_valid = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_hs_psel",  32'(M_PSELx), 32'd0);
    checkOutput("rst_hs_paddr", 32'(M_PADDR), 32'd0);

    // Read, zero wait.
    applyStimulus(16'h0012, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 16'hBEEF, 1'b0, 0, hs);
    #1;
    checkOutput("t1_lat",   32'(respCycle - hs), 32'd3);
    checkOutput("t1_paddr", 32'(M_PADDR),        32'h020012);
    checkOutput("t1_rdata", 32'(resp_rdata),     32'hBEEF);
    checkOutput("t1_err",   32'(resp_err),       32'd0);

    // Write, two wait states, ignored requests while busy.
    applyStimulus(16'h0005, 1'b1, 1'b0, 1'b0, 16'h1234, 3, 16'h5A5A, 1'b1, 0, hs);
    #1;
    checkOutput("t2_lat",    32'(respCycle - hs), 32'd5);
    checkOutput("t2_pwdata", 32'(M_PWDATA),       32'h1234);
    checkOutput("t2_paddr",  32'(M_PADDR),        32'h020005);

    // Store-exclusive with status word.
    applyStimulus(16'h0033, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1, 16'h0001, 1'b0, 0, hs);
    #1;
    checkOutput("t3_swexbit", 32'(M_PADDR[APBW-2]), 32'd1);
    checkOutput("t3_paddr",   32'(M_PADDR),         32'h0A0033);
    checkOutput("t3_rdata",   32'(resp_rdata),      32'h0001);

    // Timeout with PREADY held low.
    applyStimulus(16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 0, hs);
    #1;
    checkOutput("t4_lat",    32'(respCycle - hs), 32'd6);
    checkOutput("t4_access", 32'(accCnt),         32'd4);
    checkOutput("t4_err",    32'(resp_err),       32'd1);
    checkOutput("t4_rdata",  32'(resp_rdata),     32'd0);
    @(negedge clk);
    #1;
    checkOutput("t4_psel_after", 32'(M_PSELx), 32'd0);

    // PREADY on the same cycle the timeout would fire.
    applyStimulus(16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000, 4, 16'h4321, 1'b0, 0, hs);
    #1;
    checkOutput("t5_lat",   32'(respCycle - hs), 32'd6);
    checkOutput("t5_err",   32'(resp_err),       32'd0);
    checkOutput("t5_rdata", 32'(resp_rdata),     32'h4321);

    // Both exclusive bits set pass straight through.
    applyStimulus(16'h0044, 1'b0, 1'b1, 1'b1, 16'h0000, 2, 16'h9876, 1'b0, 0, hs);
    #1;
    checkOutput("t6_paddr", 32'(M_PADDR), 32'h1A0044);

    // Reset in the second ACCESS cycle.
    applyStimulus(16'h0300, 1'b1, 1'b0, 1'b0, 16'h5555, 0, 16'h0000, 1'b0, 3, hs);
    @(negedge clk);
    #1;
    checkOutput("abort_psel",  32'(M_PSELx),    32'd0);
    checkOutput("abort_resp",  32'(resp_valid), 32'd0);
    checkOutput("abort_paddr", 32'(M_PADDR),    32'd0);

    // Back-to-back requests: second held valid from A's RESP cycle.
    applyStimulus(16'h0400, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 16'h1111, 1'b0, 0, hsA);
    applyStimulus(16'h0401, 1'b1, 1'b0, 1'b0, 16'hABCD, 2, 16'h2222, 1'b0, 0, hsB);
    #1;
    checkOutput("b2b_gap",   32'(hsB - (hsA + 3)), 32'd1);
    checkOutput("b2b_lat",   32'(respCycle - hsB), 32'd4);
    checkOutput("b2b_rdata", 32'(resp_rdata),      32'h2222);

    repeat (3) @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

  initial begin
    #100000;
    badCount++;
    $display("[TB] FAIL watchdog: got no finish want finish by 100000");
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
